msrv32_instr_prefetch_buffer: RTL and testbench

Parametrised instruction-fetch front end between the AHB-lite instruction port and the decode stage. Issues pipelined word fetches ahead of decode and buffers returned instructions, each with its PC and a bus-fault flag, in a DEPTH-entry FIFO. Supports pipeline redirect (branch/trap/mret) with flush and discard of in-flight data. This replaces the single-word, hready-stalled fetch path of the current core.

---
 rtl/msrv32_instr_prefetch_buffer.sv | 147 ++++++++++++++
 tb/tb_msrv32_instr_prefetch_buffer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/msrv32_instr_prefetch_buffer.sv
`default_nettype none
// ============================================================================
// Module   : msrv32_instr_prefetch_buffer
// Brief    : AHB-lite instruction prefetcher with a DEPTH-entry {instr,pc,fault} FIFO
// Revision : 1.0 - initial release
// ============================================================================
module msrv32_instr_prefetch_buffer #(
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    DEPTH        = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                        ms_riscv32_mp_clk_in,
    input  logic                        ms_riscv32_mp_rst_in,
    input  logic                        redirect_in,
    input  logic [ADDR_WIDTH-1:0]       redirect_addr_in,
    input  logic                        ms_riscv32_mp_instr_hready_in,
    input  logic                        ms_riscv32_mp_hresp_in,
    input  logic [31:0]                 ms_riscv32_mp_instr_in,
    output logic [ADDR_WIDTH-1:0]       ms_riscv32_mp_imaddr_out,
    output logic [1:0]                  ms_riscv32_mp_instr_htrans_out,
    output logic                        instr_valid_out,
    input  logic                        instr_ready_in,
    output logic [31:0]                 instr_out,
    output logic [ADDR_WIDTH-1:0]       instr_pc_out,
    output logic                        instr_fault_out,
    output logic [$clog2(DEPTH):0]      occupancy_out,
    output logic                        misaligned_out
);

    localparam int                 c_PTR_W   = $clog2(DEPTH);
    localparam int                 c_CNT_W   = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH   = c_CNT_W'(DEPTH);
    localparam logic [1:0]         c_IDLE    = 2'b00;
    localparam logic [1:0]         c_NONSEQ  = 2'b10;
    localparam logic [ADDR_WIDTH-1:0] c_STEP = ADDR_WIDTH'(4);

    logic [ADDR_WIDTH-1:0] r_fetch_pc;
    logic [ADDR_WIDTH-1:0] r_data_pc;
    logic                  r_pending;
    logic                  r_discard;
    logic                  r_halt;
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_CNT_W-1:0]    r_count;

    logic [31:0]           r_instr_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_pc_mem    [DEPTH];
    logic                  r_fault_mem [DEPTH];

    logic [c_CNT_W-1:0]    w_credit_used;
    logic                  w_req;
    logic                  w_accept;
    logic                  w_complete;
    logic                  w_push;
    logic                  w_valid;
    logic                  w_pop;
    logic                  w_redirect_misaligned;

    // An in-flight data phase holds a FIFO slot so its beat always has room.
    assign w_credit_used = r_count + {{c_PTR_W{1'b0}}, r_pending};

    // Gating with the reset keeps the bus idle while reset is held.
    assign w_req      = ms_riscv32_mp_rst_in && !r_halt && !redirect_in &&
                        (w_credit_used < c_DEPTH);
    assign w_accept   = w_req && ms_riscv32_mp_instr_hready_in;
    assign w_complete = r_pending && ms_riscv32_mp_instr_hready_in;
    assign w_push     = w_complete && !r_discard && !redirect_in;
    assign w_valid    = (r_count != '0);
    assign w_pop      = w_valid && instr_ready_in && !redirect_in;

    assign w_redirect_misaligned = (redirect_addr_in[1:0] != 2'b00);

    assign ms_riscv32_mp_imaddr_out       = r_fetch_pc;
    assign ms_riscv32_mp_instr_htrans_out = w_req ? c_NONSEQ : c_IDLE;

    assign instr_valid_out = w_valid;
    assign instr_out       = w_valid ? r_instr_mem[r_rd_ptr] : '0;
    assign instr_pc_out    = w_valid ? r_pc_mem[r_rd_ptr]    : '0;
    assign instr_fault_out = w_valid ? r_fault_mem[r_rd_ptr] : 1'b0;
    assign occupancy_out   = r_count;
    assign misaligned_out  = r_halt;

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (w_push) begin
            r_instr_mem[r_wr_ptr] <= ms_riscv32_mp_instr_in;
            r_pc_mem[r_wr_ptr]    <= r_data_pc;
            r_fault_mem[r_wr_ptr] <= ms_riscv32_mp_hresp_in;
        end
    end

    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
        if (!ms_riscv32_mp_rst_in) begin
            r_fetch_pc <= RESET_VECTOR;
            r_data_pc  <= '0;
            r_pending  <= 1'b0;
            r_discard  <= 1'b0;
            r_halt     <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            // Bus data-phase tracking
            if (w_accept) begin
                r_pending <= 1'b1;
                r_data_pc <= r_fetch_pc;
            end else if (w_complete) begin
                r_pending <= 1'b0;
            end

            if (redirect_in) begin
                // A phase still waiting on hready finishes later and is dropped.
                r_discard <= r_pending && !ms_riscv32_mp_instr_hready_in;
            end else if (w_accept || w_complete) begin
                r_discard <= 1'b0;
            end

            if (redirect_in) begin
                r_fetch_pc <= redirect_addr_in;
                r_halt     <= w_redirect_misaligned;
            end else if (w_accept) begin
                r_fetch_pc <= r_fetch_pc + c_STEP;
            end

            // FIFO bookkeeping
            if (redirect_in) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_msrv32_instr_prefetch_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_msrv32_instr_prefetch_buffer
// Brief    : Randomised scoreboard bench with an AHB memory model for the prefetcher
// Revision : 1.0 - initial release
// ============================================================================
module tb_msrv32_instr_prefetch_buffer;

    localparam int AW    = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          redirect = 1'b0;
    logic [AW-1:0] redirect_addr = '0;
    logic          hready = 1'b1;
    logic          hresp = 1'b0;
    logic [31:0]   hrdata = '0;
    logic [AW-1:0] imaddr;
    logic [1:0]    htrans;
    logic          valid;
    logic          instr_ready = 1'b0;
    logic [31:0]   instr;
    logic [AW-1:0] instr_pc;
    logic          fault;
    logic [2:0]    occupancy;
    logic          misaligned;

    msrv32_instr_prefetch_buffer #(
        .ADDR_WIDTH   (AW),
        .DEPTH        (DEPTH),
        .RESET_VECTOR (32'h0000_0000)
    ) dut (
        .ms_riscv32_mp_clk_in           (clk),
        .ms_riscv32_mp_rst_in           (rst_n),
        .redirect_in                    (redirect),
        .redirect_addr_in               (redirect_addr),
        .ms_riscv32_mp_instr_hready_in  (hready),
        .ms_riscv32_mp_hresp_in         (hresp),
        .ms_riscv32_mp_instr_in         (hrdata),
        .ms_riscv32_mp_imaddr_out       (imaddr),
        .ms_riscv32_mp_instr_htrans_out (htrans),
        .instr_valid_out                (valid),
        .instr_ready_in                 (instr_ready),
        .instr_out                      (instr),
        .instr_pc_out                   (instr_pc),
        .instr_fault_out                (fault),
        .occupancy_out                  (occupancy),
        .misaligned_out                 (misaligned)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0]   instr;
        logic [AW-1:0] pc;
        logic          fault;
    } entry_t;

    // Reference model: the decode-visible instruction stream plus the one bus beat in flight.
    entry_t        exp_q[$];
    logic [AW-1:0] m_pc       = '0;
    logic          m_halt     = 1'b0;
    logic          m_dp_valid = 1'b0;
    logic          m_dp_stale = 1'b0;
    logic [AW-1:0] m_dp_addr  = '0;
    entry_t        mon_e;

    int tests = 0;
    int fails = 0;

    function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, then advance the model.
    task automatic body(input logic rdy, input logic hr, input logic resp,
                        input logic redir, input logic [AW-1:0] raddr);
        logic req;
        logic complete;
        instr_ready   = rdy;
        hready        = hr;
        hresp         = resp;
        redirect      = redir;
        redirect_addr = raddr;
        hrdata        = m_dp_valid ? mem_word(m_dp_addr) : $urandom;
        #1;
        req = !m_halt && !redir && ((exp_q.size() + (m_dp_valid ? 1 : 0)) < DEPTH);
        check("htrans", {30'd0, htrans}, req ? 32'd2 : 32'd0);
        if (req) check("imaddr", imaddr, m_pc);
        check("occupancy", {29'd0, occupancy}, exp_q.size());
        check("valid", {31'd0, valid}, {31'd0, exp_q.size() != 0});
        check("misaligned", {31'd0, misaligned}, {31'd0, m_halt});

        complete = m_dp_valid && hr;
        if (redir) begin
            exp_q.delete();
            if (complete) m_dp_valid = 1'b0;
            else          m_dp_stale = 1'b1;
            m_pc   = raddr;
            m_halt = (raddr[1:0] != 2'b00);
        end else begin
            if (complete) begin
                if (!m_dp_stale) exp_q.push_back('{mem_word(m_dp_addr), m_dp_addr, resp});
                m_dp_valid = 1'b0;
            end
            if (req && hr) begin
                m_dp_valid = 1'b1;
                m_dp_stale = 1'b0;
                m_dp_addr  = m_pc;
                m_pc       = m_pc + 32'd4;
            end
        end
    endtask

    task automatic cycle(input logic rdy, input logic hr, input logic resp,
                         input logic redir, input logic [AW-1:0] raddr);
        @(negedge clk);
        body(rdy, hr, resp, redir, raddr);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n       = 1'b0;
        redirect    = 1'b0;
        instr_ready = 1'b0;
        hready      = 1'b1;
        #1;
        check("rst_htrans", {30'd0, htrans}, 32'd0);
        check("rst_imaddr", imaddr, 32'd0);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_pc", instr_pc, 32'd0);
        check("rst_fault", {31'd0, fault}, 32'd0);
        check("rst_occupancy", {29'd0, occupancy}, 32'd0);
        check("rst_misaligned", {31'd0, misaligned}, 32'd0);
        exp_q.delete();
        m_pc       = '0;
        m_halt     = 1'b0;
        m_dp_valid = 1'b0;
        m_dp_stale = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        body(1'b0, 1'b1, 1'b0, 1'b0, '0);
    endtask

    // Monitor: every head consumed by decode must be the next expected instruction.
    always @(negedge clk) begin
        #2;
        if (rst_n && valid && instr_ready && !redirect) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL pop_unexpected: got pc %h expected no entry at %0t", instr_pc, $time);
            end else begin
                mon_e = exp_q.pop_front();
                check("head_instr", instr, mon_e.instr);
                check("head_pc", instr_pc, mon_e.pc);
                check("head_fault", {31'd0, fault}, {31'd0, mon_e.fault});
            end
        end
    end

    initial begin
        logic [AW-1:0] a;
        do_reset();
        repeat (8)  cycle(1'b0, 1'b1, 1'b0, 1'b0, '0);
        repeat (12) cycle(1'b1, 1'b1, 1'b0, 1'b0, '0);
        // Wait states in a data phase
        cycle(1'b1, 1'b1, 1'b0, 1'b0, '0);
        repeat (3)  cycle(1'b1, 1'b0, 1'b0, 1'b0, '0);
        repeat (4)  cycle(1'b1, 1'b1, 1'b0, 1'b0, '0);
        // Redirect with buffered entries and a beat in flight, plus one stalled beat
        repeat (2)  cycle(1'b0, 1'b1, 1'b0, 1'b0, '0);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 32'h100);
        repeat (6)  cycle(1'b1, 1'b1, 1'b0, 1'b0, '0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h180);
        repeat (2)  cycle(1'b1, 1'b0, 1'b0, 1'b0, '0);
        repeat (6)  cycle(1'b1, 1'b1, 1'b0, 1'b0, '0);
        // Bus error on the fetch at 0x8
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 32'h0);
        repeat (8)  cycle(1'b1, 1'b1, m_dp_valid && (m_dp_addr == 32'h8), 1'b0, '0);
        // Misaligned halt and recovery
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 32'h102);
        repeat (6)  cycle(1'b1, 1'b1, 1'b0, 1'b0, '0);
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 32'h200);
        repeat (6)  cycle(1'b1, 1'b1, 1'b0, 1'b0, '0);
        // Address wrap
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFF8);
        repeat (6)  cycle(1'b1, 1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 500; i++) begin
            case ($urandom_range(0, 4))
                0:       a = 32'h100;
                1:       a = 32'h102;
                2:       a = 32'h200;
                3:       a = $urandom & 32'hFFFF_FFFC;
                default: a = 32'hFFFF_FFFC;
            endcase
            cycle($urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 99) < 4, a);
        end
        // Reset in the middle of traffic
        repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b0, '0);
        do_reset();
        repeat (10) cycle($urandom_range(0, 1) != 0, 1'b1, 1'b0, 1'b0, '0);
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
